// File: rtl/ip_pkg.sv
// Shared IPv4 header constants and helpers, used by the transmit and receive header blocks.
package ip_pkg;

    localparam logic [7:0]  IPHL        = 8'h45;
    localparam logic [7:0]  TOS         = 8'h00;
    localparam logic [15:0] FLAG_OFFSET = 16'h0000;
    localparam logic [7:0]  IP_UDP_TYPE = 8'h11;
    localparam int          IP_HDR_LEN  = 20;

    // Total length wraps mod 2^16; upstream keeps udp_len small enough that it never does.
    function automatic logic [15:0] ip_total_len(input logic [15:0] udp_len);
        return udp_len + 16'(IP_HDR_LEN);
    endfunction

endpackage

// File: rtl/ip_csum_fold.sv
// Ones-complement checksum finish: folds a 32-bit running sum to 16 bits and inverts it.
module ip_csum_fold (
    input  logic [31:0] i_acc,
    output logic [15:0] o_csum
);

    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // After the first fold the value is at most 0x1FFFE, so the second fold cannot carry again.
    assign w_fold1 = {1'b0, i_acc[15:0]} + {1'b0, i_acc[31:16]};
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    assign o_csum  = ~w_fold2;

endmodule

// File: rtl/ip_header_tx.sv
// IPv4 header generator: latches addresses/length on start, sums the header over five cycles,
// folds the checksum, then streams the 20 header bytes MSB-first on a valid/ready byte port.
module ip_header_tx
    import ip_pkg::*;
#(
    parameter logic [7:0]  TTL     = 8'hFF,
    parameter logic [15:0] ID_INIT = 16'h0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [15:0] udp_len,
    input  logic [31:0] ip_s_addr,
    input  logic [31:0] ip_d_addr,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        data_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FOLD,
        S_SEND
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(IP_HDR_LEN - 1);
    localparam logic [2:0] LAST_CNT = 3'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [4:0]  r_idx;
    logic [31:0] r_acc;
    logic [15:0] r_csum;
    logic [15:0] r_id;
    logic [15:0] r_udp_len;
    logic [31:0] r_s_addr;
    logic [31:0] r_d_addr;

    logic        w_handshake;
    logic [15:0] w_total_len;
    logic [15:0] w_word_a;
    logic [15:0] w_word_b;
    logic [15:0] w_csum;
    logic [159:0] w_hdr;
    logic [7:0]  w_hdr_bytes [IP_HDR_LEN];

    assign w_total_len = ip_total_len(r_udp_len);
    assign w_handshake = (r_state == S_SEND) && data_ready;

    assign w_hdr = {IPHL, TOS, w_total_len, r_id, FLAG_OFFSET,
                    TTL, IP_UDP_TYPE, r_csum, r_s_addr, r_d_addr};

    for (genvar gi = 0; gi < IP_HDR_LEN; gi++) begin : g_hdr_bytes
        assign w_hdr_bytes[gi] = w_hdr[159 - 8*gi -: 8];
    end

    // One pair of header words per CALC cycle; the checksum field itself counts as zero.
    always_comb begin
        w_word_a = 16'h0000;
        w_word_b = 16'h0000;
        case (r_cnt)
            3'd0: begin w_word_a = {IPHL, TOS};       w_word_b = w_total_len;      end
            3'd1: begin w_word_a = r_id;              w_word_b = FLAG_OFFSET;      end
            3'd2: begin w_word_a = {TTL, IP_UDP_TYPE}; w_word_b = 16'h0000;        end
            3'd3: begin w_word_a = r_s_addr[31:16];   w_word_b = r_s_addr[15:0];   end
            3'd4: begin w_word_a = r_d_addr[31:16];   w_word_b = r_d_addr[15:0];   end
            default: begin w_word_a = 16'h0000;       w_word_b = 16'h0000;         end
        endcase
    end

    ip_csum_fold u_csum_fold (
        .i_acc  (r_acc),
        .o_csum (w_csum)
    );

    always_comb begin
        w_state_next = r_state;
        data_valid   = 1'b0;
        data_last    = 1'b0;
        data_out     = 8'h00;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (start) w_state_next = S_CALC;
            S_CALC: if (r_cnt == LAST_CNT) w_state_next = S_FOLD;
            S_FOLD: w_state_next = S_SEND;
            S_SEND: begin
                data_valid = 1'b1;
                data_out   = w_hdr_bytes[r_idx];
                data_last  = (r_idx == LAST_IDX);
                if (w_handshake && (r_idx == LAST_IDX)) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_idx     <= 5'd0;
            r_acc     <= 32'd0;
            r_csum    <= 16'h0000;
            r_id      <= ID_INIT;
            r_udp_len <= 16'h0000;
            r_s_addr  <= 32'd0;
            r_d_addr  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_udp_len <= udp_len;
                        r_s_addr  <= ip_s_addr;
                        r_d_addr  <= ip_d_addr;
                        r_acc     <= 32'd0;
                        r_cnt     <= 3'd0;
                    end
                end
                S_CALC: begin
                    r_acc <= r_acc + 32'(w_word_a) + 32'(w_word_b);
                    r_cnt <= r_cnt + 3'd1;
                end
                S_FOLD: begin
                    r_csum <= w_csum;
                    r_idx  <= 5'd0;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_idx <= r_idx + 5'd1;
                        if (r_idx == LAST_IDX) r_id <= r_id + 16'h0001;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_tx.sv
// Randomized self-checking bench for ip_header_tx against a byte-level IPv4 header model.
module tb_ip_header_tx;

    typedef logic [7:0] hdr_t [20];

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] udp_len = 16'h0;
    logic [31:0] ip_s_addr = 32'h0;
    logic [31:0] ip_d_addr = 32'h0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        data_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_id = 0;

    hdr_t p1_ref = '{8'h45, 8'h00, 8'h05, 8'hDC, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h11,
                     8'h34, 8'hB5, 8'hC0, 8'hA8, 8'h00, 8'h0A, 8'hC0, 8'hA8, 8'h00, 8'h01};

    ip_header_tx #(
        .TTL     (8'hFF),
        .ID_INIT (16'h0000)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .udp_len    (udp_len),
        .ip_s_addr  (ip_s_addr),
        .ip_d_addr  (ip_d_addr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_last  (data_last),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Header built field by field, checksum = ones-complement of the ones-complement word sum.
    function automatic void model_hdr(input logic [15:0] len, input logic [15:0] id,
                                      input logic [31:0] s, input logic [31:0] d, output hdr_t h);
        logic [15:0] tl;
        logic [15:0] cs;
        int unsigned sum;
        tl = len + 16'd20;
        h = '{default: 8'h00};
        h[0] = 8'h45;  h[2] = tl[15:8];  h[3] = tl[7:0];
        h[4] = id[15:8]; h[5] = id[7:0];
        h[8] = 8'hFF;  h[9] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            h[12 + i] = s[31 - 8*i -: 8];
            h[16 + i] = d[31 - 8*i -: 8];
        end
        sum = 0;
        for (int i = 0; i < 10; i++) sum += {16'h0, h[2*i], h[2*i + 1]};
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        h[10] = cs[15:8];
        h[11] = cs[7:0];
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic run_header(input logic [15:0] len, input logic [31:0] s, input logic [31:0] d,
                              input int stall_byte, input int stall_len, input bit rnd,
                              input bit disturb, input int abort_at,
                              output hdr_t got, output int first_c, output int last_c,
                              output int n_got);
        int  c = 1;
        int  stall_cnt = 0;
        bit  held = 0;
        logic [7:0] held_byte = 8'h00;
        got = '{default: 8'h00};
        first_c = -1;
        last_c = -1;
        n_got = 0;
        udp_len = len; ip_s_addr = s; ip_d_addr = d;
        start = 1'b1;
        data_ready = rnd ? 1'b0 : 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        while (n_got < 20 && c < 300) begin
            if (held) begin
                check_val("hold_data", {24'h0, data_out}, {24'h0, held_byte});
                check_val("hold_valid", {31'h0, data_valid}, 32'h1);
            end
            if (c == 1) check_val("busy_calc", {31'h0, busy}, 32'h1);
            if (disturb && c == 2) begin
                udp_len   = 16'($urandom);
                ip_s_addr = $urandom;
                ip_d_addr = $urandom;
            end
            if (disturb) start = (c == 12);
            if (data_valid && first_c < 0) first_c = c;
            if (abort_at >= 0 && data_valid && n_got == abort_at) begin
                aresetn = 1'b0;
                #1;
                check_val("abort_valid", {31'h0, data_valid}, 32'h0);
                check_val("abort_data", {24'h0, data_out}, 32'h0);
                check_val("abort_last", {31'h0, data_last}, 32'h0);
                check_val("abort_busy", {31'h0, busy}, 32'h0);
                model_id = 0;
                data_ready = 1'b0;
                @(posedge aclk); @(posedge aclk); #1;
                aresetn = 1'b1;
                @(posedge aclk); #1;
                return;
            end
            if (rnd) data_ready = ($urandom_range(0, 3) != 0);
            else if (data_valid && n_got == stall_byte && stall_cnt < stall_len) begin
                data_ready = 1'b0;
                stall_cnt++;
            end else data_ready = 1'b1;
            held = data_valid && !data_ready;
            held_byte = data_out;
            if (data_valid && data_ready) begin
                got[n_got] = data_out;
                check_val($sformatf("last_b%0d", n_got), {31'h0, data_last},
                          {31'h0, (n_got == 19)});
                if (n_got == 19) last_c = c;
                n_got++;
            end
            @(posedge aclk); #1;
            c++;
        end
        start = 1'b0;
        data_ready = 1'b0;
        if (n_got < 20) check_val("timeout_bytes", n_got, 20);
        else begin
            check_val("busy_after", {31'h0, busy}, 32'h0);
            check_val("valid_after", {31'h0, data_valid}, 32'h0);
        end
    endtask

    task automatic do_pkt(input logic [15:0] len, input logic [31:0] s, input logic [31:0] d,
                          input int stall_byte, input int stall_len, input bit rnd,
                          input bit disturb, input int abort_at, output hdr_t got);
        hdr_t exp;
        int first_c, last_c, n_got;
        run_header(len, s, d, stall_byte, stall_len, rnd, disturb, abort_at,
                   got, first_c, last_c, n_got);
        if (abort_at >= 0) begin
            $display("hdr len=%h src=%h dst=%h aborted after %0d bytes", len, s, d, n_got);
            return;
        end
        model_hdr(len, 16'(model_id), s, d, exp);
        for (int i = 0; i < 20; i++)
            check_val($sformatf("byte%0d", i), {24'h0, got[i]}, {24'h0, exp[i]});
        check_val("first_cycle", first_c, 7);
        if (!rnd) check_val("last_cycle", last_c, 26 + ((stall_byte >= 0) ? stall_len : 0));
        model_id = (model_id + 1) & 16'hFFFF;
        $display("hdr len=%h src=%h dst=%h id=%02h%02h csum=%02h%02h first=%0d last=%0d",
                 len, s, d, got[4], got[5], got[10], got[11], first_c, last_c);
    endtask

    initial begin
        hdr_t got;
        repeat (3) @(posedge aclk);
        #1;
        check_val("rst_valid", {31'h0, data_valid}, 32'h0);
        check_val("rst_data", {24'h0, data_out}, 32'h0);
        check_val("rst_last", {31'h0, data_last}, 32'h0);
        check_val("rst_busy", {31'h0, busy}, 32'h0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        do_pkt(16'h05C8, 32'hC0A8000A, 32'hC0A80001, -1, 0, 1'b0, 1'b0, -1, got);
        for (int i = 0; i < 20; i++)
            check_val($sformatf("p1_byte%0d", i), {24'h0, got[i]}, {24'h0, p1_ref[i]});

        do_pkt(16'h05C8, 32'hC0A8000A, 32'hC0A80001, -1, 0, 1'b0, 1'b0, -1, got);
        check_val("p2_id", {16'h0, got[4], got[5]}, 32'h0001);
        check_val("p2_csum", {16'h0, got[10], got[11]}, 32'h34B4);

        do_pkt(16'h0100, 32'h0A000001, 32'h0A0000FE, 7, 3, 1'b0, 1'b0, -1, got);

        do_pkt(16'h0020, 32'h11223344, 32'h55667788, -1, 0, 1'b0, 1'b1, -1, got);
        for (int i = 0; i < 30; i++) begin
            check_val("no_requeue", {31'h0, busy | data_valid}, 32'h0);
            @(posedge aclk); #1;
        end

        do_pkt(16'h05C8, 32'hC0A8000A, 32'hC0A80001, -1, 0, 1'b0, 1'b0, 12, got);
        do_pkt(16'h05C8, 32'hC0A8000A, 32'hC0A80001, -1, 0, 1'b0, 1'b0, -1, got);
        check_val("post_rst_id", {16'h0, got[4], got[5]}, 32'h0000);

        for (int k = 0; k < 10; k++) begin
            logic [15:0] len;
            len = 16'($urandom_range(0, 1480));
            if (k % 3 == 0)
                do_pkt(len, $urandom, $urandom, int'($urandom_range(0, 19)),
                       int'($urandom_range(1, 4)), 1'b0, 1'b0, -1, got);
            else
                do_pkt(len, $urandom, $urandom, -1, 0, 1'b1, 1'b0, -1, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_header_tx.md
# ip_header_tx

Transmit-side IPv4 header generator for the UDP/IP/Ethernet byte-stream path. On a start request it latches the source/destination addresses and the UDP length, and computes the IPv4 header checksum over a fixed 5-cycle schedule. It then emits the 20-byte header MSB-first on an 8-bit valid/ready stream. It sits between the Ethernet-header transmitter (upstream) and the UDP-header transmitter (downstream). Its output is accepted byte-for-byte by `ip_header_rx`.

## Interface
Parameters:
- `TTL`, 8'hFF, time-to-live byte placed in header byte 8.
- `ID_INIT`, 16'h0000, identification value used for the first header after reset.

Ports:
- `aclk`  in  1  single clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a header; sampled only in IDLE.
- `udp_len`  in  16  UDP length (UDP header plus payload), latched on `start`.
- `ip_s_addr`  in  32  source address, latched on `start`.
- `ip_d_addr`  in  32  destination address, latched on `start`.
- `data_out`  out  8  header byte.
- `data_valid`  out  1  `data_out` is valid.
- `data_ready`  in  1  downstream accepts the byte when `data_valid & data_ready`.
- `data_last`  out  1  high together with header byte 19.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after the last handshake.

Reset values: `data_out` = 0, `data_valid` = 0, `data_last` = 0, `busy` = 0. Internal: state = IDLE, ID counter = `ID_INIT`, accumulator = 0.

## Operation
Header byte order (index 0..19), all multi-byte fields MSB first:
- Byte 0 = 0x45; byte 1 = 0x00.
- Bytes 2-3 = total length = `udp_len` + 20, truncated mod 2^16. No saturation; upstream guarantees `udp_len` ≤ 1480.
- Bytes 4-5 = ID; bytes 6-7 = 0x0000 (flags/offset).
- Byte 8 = `TTL`; byte 9 = 0x11 (UDP); bytes 10-11 = checksum.
- Bytes 12-15 = source address; bytes 16-19 = destination address.

FSM states:
- IDLE: `start` = 1 latches the inputs, clears the 32-bit accumulator, goes to CALC.
- CALC: a 3-bit counter runs 0..4. Each cycle adds one pair of 16-bit words to the 32-bit accumulator:
  - 0: {0x45,0x00} + total length
  - 1: ID + 0x0000
  - 2: {TTL,0x11} + 0x0000
  - 3: src[31:16] + src[15:0]
  - 4: dst[31:16] + dst[15:0]
  - Counter = 4 goes to FOLD.
- FOLD: end-around-carry fold is applied twice (low16 + (acc>>16), then repeated); result is inverted and registered as the checksum. Goes to SEND with the byte index at 0.
- SEND: `data_valid` = 1 and `data_out` = header[index]. On handshake the index increments. Handshake at index 19 goes to IDLE and increments the ID counter (wraps 0xFFFF→0x0000).

Boundary conditions:
- `start` while `busy` is ignored and not queued.
- `data_ready` low holds `data_out`, `data_valid` and `data_last` stable.
- `data_ready` may be high before `data_valid`.
- Input changes after the `start` cycle have no effect on the header in flight.
- Asserting `aresetn` mid-header aborts it immediately. Outputs return to reset values and the ID returns to `ID_INIT`; no partial header resumes.

## Timing
- Cycle N: `start` = 1 in IDLE.
- N+1 to N+5: CALC (`busy` = 1).
- N+6: FOLD.
- N+7: byte 0 valid.
- With `data_ready` held high, bytes 0..19 occupy N+7..N+26. `data_last` is high at N+26, and IDLE with `busy` = 0 follows at N+27.
- Earliest next accepted `start` is at N+27. Back-to-back headers therefore take 27 cycles each.
- Each low cycle of `data_ready` during SEND adds exactly one cycle.

## Structure
- Shared package `ip_pkg` holds constants IPHL = 8'h45, TOS = 8'h00, FLAG_OFFSET = 16'h0000, IP_UDP_TYPE = 8'h11 and IP_HDR_LEN = 20. `ip_header_rx` uses the same package.
- The FSM state enum is local to the module.
- One sub-module: `ip_csum_fold`, combinational 32→16 double fold plus inversion. It is reusable by `ip_header_rx` and the future UDP checksum.

## Test plan
- Packet 1: `udp_len` = 0x05C8, src = C0A8000A, dst = C0A80001, `TTL` = FF, `ID_INIT` = 0, `data_ready` = 1.
  - Required bytes: 45 00 05 DC 00 00 00 00 FF 11 34 B5 C0 A8 00 0A C0 A8 00 01.
  - Byte 0 at N+7; `data_last` only on byte 19.
- Second packet with the same inputs: ID = 0x0001, checksum = 0x34B4.
- Loopback into `ip_header_rx` with matching addresses: `ip_header_valid` pulses once per header.
- `data_ready` low for 3 cycles while byte 7 is presented: byte 7 is held for 4 cycles, the last byte is delayed by 3 cycles, and no byte is lost or duplicated.
- `start` pulsed during SEND, and `ip_s_addr` changed during CALC: no second header, and the first header is unchanged.
- `aresetn` low at byte 12:
  - All outputs return to 0 asynchronously.
  - After release, a new `start` yields ID = `ID_INIT` and a correct full header.
